// File: rtl/wb_mailbox_if.sv
// Classic Wishbone B4 bus bundle. Signal directions are named from the master's
// point of view: dat_o carries write data, dat_i carries read data.
interface wishbone;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;
    logic        rty;
    logic [2:0]  cti;
    logic [1:0]  bte;

    modport master (
        output adr, dat_o, sel, we, cyc, stb, cti, bte,
        input  dat_i, ack, err, rty
    );

    modport slave (
        input  adr, dat_o, sel, we, cyc, stb, cti, bte,
        output dat_i, ack, err, rty
    );
endinterface

// File: rtl/wb_mailbox.sv
// Wishbone mailbox: TX FIFO (bus -> stream), RX FIFO (stream -> bus) and CTRL/STATUS.
// Define WB_MAILBOX_ERR_EN to answer TX-full writes and RX-empty reads with err.
module wb_mailbox #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wishbone.slave      wb,
    output logic        tx_valid_o,
    output logic [31:0] tx_data_o,
    input  logic        tx_ready_i,
    input  logic        rx_valid_i,
    input  logic [31:0] rx_data_i,
    output logic        rx_ready_o,
    output logic        irq_o
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // One-hot response encoding so ack/err come straight off flop bits.
    typedef enum logic [1:0] {
        BUS_IDLE = 2'b00,
        BUS_ACK  = 2'b01,
        BUS_ERR  = 2'b10
    } bus_state_e;

    bus_state_e    state_q, state_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic          tx_push_pend_q, tx_push_pend_d;
    logic          rx_pop_pend_q, rx_pop_pend_d;
    logic          ctrl_pend_q, ctrl_pend_d;
    logic          irq_en_q, irq_en_d;
    logic          irq_q, irq_d;

    logic [DW-1:0] tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic          tx_valid_q, tx_valid_d;

    logic [DW-1:0] rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic          rx_ready_q, rx_ready_d;

    logic          bus_req;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, tx_flush;
    logic          rx_push, rx_pop, rx_flush;
    logic [DW-1:0] status;
    logic          unused_bits;

    assign tx_full  = (tx_cnt_q == CW'(DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);

    assign status = {8'd0, 8'(rx_cnt_q), 8'(tx_cnt_q), 4'd0,
                     rx_empty, rx_full, tx_empty, tx_full};

    // A new request is only taken while no response is on the bus.
    assign bus_req = wb.cyc & wb.stb & (state_q == BUS_IDLE);

    // Bus commits are scheduled here and applied at the end of the response cycle.
    assign tx_push  = tx_push_pend_q;
    assign tx_pop   = tx_valid_q & tx_ready_i;
    assign tx_flush = ctrl_pend_q & wdat_q[1];
    assign rx_push  = rx_valid_i & rx_ready_q;
    assign rx_pop   = rx_pop_pend_q;
    assign rx_flush = ctrl_pend_q & wdat_q[2];

    // Request decode: decide the response and latch the commit for the next edge.
    always_comb begin : bus_comb
        state_d        = BUS_IDLE;
        dat_d          = '0;
        wdat_d         = wdat_q;
        tx_push_pend_d = 1'b0;
        rx_pop_pend_d  = 1'b0;
        ctrl_pend_d    = 1'b0;
        if (bus_req) begin
            state_d = BUS_ACK;
            unique case (wb.adr[3:2])
                REG_DATA: begin
                    if (wb.we) begin
                        if (tx_full) begin
`ifdef WB_MAILBOX_ERR_EN
                            state_d = BUS_ERR;
`endif
                        end else begin
                            tx_push_pend_d = 1'b1;
                            wdat_d         = wb.dat_o;
                        end
                    end else begin
                        if (rx_empty) begin
`ifdef WB_MAILBOX_ERR_EN
                            state_d = BUS_ERR;
`endif
                        end else begin
                            rx_pop_pend_d = 1'b1;
                            dat_d         = rx_mem[rx_rd_q];
                        end
                    end
                end
                REG_STATUS: begin
                    if (!wb.we) begin
                        dat_d = status;
                    end
                end
                REG_CTRL: begin
                    if (wb.we) begin
                        ctrl_pend_d = wb.sel[0];
                        wdat_d      = wb.dat_o;
                    end else begin
                        dat_d = {31'd0, irq_en_q};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin : tx_comb
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_flush) begin
            tx_wr_d  = '0;
            tx_rd_d  = '0;
            tx_cnt_d = '0;
        end else begin
            if (tx_push) begin
                tx_wr_d = tx_wr_q + AW'(1);
            end
            if (tx_pop) begin
                tx_rd_d = tx_rd_q + AW'(1);
            end
            unique case ({tx_push, tx_pop})
                2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
                2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
                default: tx_cnt_d = tx_cnt_q;
            endcase
        end
        tx_valid_d = (tx_cnt_d != '0);
    end

    always_comb begin : rx_comb
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_flush) begin
            rx_wr_d  = '0;
            rx_rd_d  = '0;
            rx_cnt_d = '0;
        end else begin
            if (rx_push) begin
                rx_wr_d = rx_wr_q + AW'(1);
            end
            if (rx_pop) begin
                rx_rd_d = rx_rd_q + AW'(1);
            end
            unique case ({rx_push, rx_pop})
                2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
                2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
                default: rx_cnt_d = rx_cnt_q;
            endcase
        end
        rx_ready_d = (rx_cnt_d != CW'(DEPTH));
    end

    always_comb begin : ctrl_comb
        irq_en_d = ctrl_pend_q ? wdat_q[0] : irq_en_q;
        irq_d    = irq_en_q & ~rx_empty;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin : regs
        if (!rst_i) begin
            state_q        <= BUS_IDLE;
            dat_q          <= '0;
            wdat_q         <= '0;
            tx_push_pend_q <= 1'b0;
            rx_pop_pend_q  <= 1'b0;
            ctrl_pend_q    <= 1'b0;
            irq_en_q       <= 1'b0;
            irq_q          <= 1'b0;
            tx_wr_q        <= '0;
            tx_rd_q        <= '0;
            tx_cnt_q       <= '0;
            tx_valid_q     <= 1'b0;
            rx_wr_q        <= '0;
            rx_rd_q        <= '0;
            rx_cnt_q       <= '0;
            rx_ready_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            dat_q          <= dat_d;
            wdat_q         <= wdat_d;
            tx_push_pend_q <= tx_push_pend_d;
            rx_pop_pend_q  <= rx_pop_pend_d;
            ctrl_pend_q    <= ctrl_pend_d;
            irq_en_q       <= irq_en_d;
            irq_q          <= irq_d;
            tx_wr_q        <= tx_wr_d;
            tx_rd_q        <= tx_rd_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_valid_q     <= tx_valid_d;
            rx_wr_q        <= rx_wr_d;
            rx_rd_q        <= rx_rd_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_ready_q     <= rx_ready_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin : tx_store
        if (tx_push && !tx_flush) begin
            tx_mem[tx_wr_q] <= wdat_q;
        end
    end

    always_ff @(posedge clk_i) begin : rx_store
        if (rx_push && !rx_flush) begin
            rx_mem[rx_wr_q] <= rx_data_i;
        end
    end

    assign wb.ack   = state_q[0];
`ifdef WB_MAILBOX_ERR_EN
    assign wb.err   = state_q[1];
`else
    assign wb.err   = 1'b0;
`endif
    assign wb.rty   = 1'b0;
    assign wb.dat_i = dat_q;

    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_mem[tx_rd_q];
    assign rx_ready_o = rx_ready_q;
    assign irq_o      = irq_q;

    assign unused_bits = ^{wb.adr[31:4], wb.adr[1:0], wb.sel[3:1], wb.cti, wb.bte};

endmodule

// File: tb/tb_wb_mailbox.sv
// Scoreboard bench for wb_mailbox: bus responses and TX stream words are checked
// against queues of expected values filled when stimulus is issued.
module tb_wb_mailbox;

    localparam logic [1:0] R_DATA   = 2'd0;
    localparam logic [1:0] R_STATUS = 2'd1;
    localparam logic [1:0] R_CTRL   = 2'd2;
    localparam logic [1:0] R_RSV    = 2'd3;

`ifdef WB_MAILBOX_ERR_EN
    localparam logic EXP_OVF_ERR = 1'b1;
`else
    localparam logic EXP_OVF_ERR = 1'b0;
`endif

    typedef struct packed {
        logic        is_err;
        logic        chk;
        logic [31:0] dat;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;
    logic [31:0] tx_data, rx_data;

    wishbone wb_bus();

    wb_mailbox #(.DEPTH(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .wb         (wb_bus),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .tx_ready_i (tx_ready),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .rx_ready_o (rx_ready),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    rsp_t        rsp_q[$];
    logic [31:0] tx_exp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop one expected entry per bus response and per TX handshake.
    always @(negedge clk) begin : monitor
        rsp_t        e;
        logic [31:0] te;
        if (wb_bus.ack || wb_bus.err) begin
            if (rsp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got ack=%b err=%b with nothing expected at %0t",
                         wb_bus.ack, wb_bus.err, $time);
            end else begin
                e = rsp_q.pop_front();
                check("rsp_err", 32'(wb_bus.err), 32'(e.is_err));
                check("rsp_ack", 32'(wb_bus.ack), 32'(!e.is_err));
                if (e.chk) check("rsp_dat", wb_bus.dat_i, e.dat);
            end
        end
        if (tx_valid && tx_ready) begin
            if (tx_exp.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_tx: got %h with nothing expected at %0t", tx_data, $time);
            end else begin
                te = tx_exp.pop_front();
                check("tx_order", tx_data, te);
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [1:0] reg_i, input logic [31:0] wdat,
                           input logic [3:0] sel, input logic exp_err, input logic chk,
                           input logic [31:0] exp_dat);
        rsp_t e;
        int   lat;
        @(posedge clk); #1;
        e.is_err = exp_err;
        e.chk    = chk;
        e.dat    = exp_dat;
        rsp_q.push_back(e);
        wb_bus.adr   = ($urandom() & 32'hFFFF_FFF3) | 32'({reg_i, 2'b00});
        wb_bus.we    = we;
        wb_bus.dat_o = wdat;
        wb_bus.sel   = sel;
        wb_bus.cti   = 3'($urandom_range(0, 7));
        wb_bus.bte   = 2'($urandom_range(0, 3));
        wb_bus.cyc   = 1'b1;
        wb_bus.stb   = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(wb_bus.ack || wb_bus.err) && lat < 10);
        check("latency", 32'(lat), 32'd2);
        @(posedge clk); #1;
        wb_bus.cyc = 1'b0;
        wb_bus.stb = 1'b0;
        wb_bus.we  = 1'b0;
    endtask

    task automatic wb_rd(input logic [1:0] reg_i, input logic [31:0] exp);
        wb_xfer(1'b0, reg_i, 32'h0, 4'hF, 1'b0, 1'b1, exp);
    endtask

    task automatic wb_wr(input logic [1:0] reg_i, input logic [31:0] dat, input logic [3:0] sel);
        wb_xfer(1'b1, reg_i, dat, sel, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic tx_write(input logic [31:0] dat, input logic [3:0] sel, input logic track);
        if (track) tx_exp.push_back(dat);
        wb_wr(R_DATA, dat, sel);
    endtask

    initial begin : stim
        rst_n        = 1'b0;
        wb_bus.adr   = '0;
        wb_bus.dat_o = '0;
        wb_bus.sel   = '0;
        wb_bus.we    = 1'b0;
        wb_bus.cyc   = 1'b0;
        wb_bus.stb   = 1'b0;
        wb_bus.cti   = '0;
        wb_bus.bte   = '0;
        tx_ready     = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = '0;

        repeat (3) @(negedge clk);
        check("rst_ack", 32'(wb_bus.ack), 32'd0);
        check("rst_err", 32'(wb_bus.err), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        wb_rd(R_STATUS, 32'h0000_000A);

        // stb held across two accesses: response, one idle cycle, response
        @(posedge clk); #1;
        rsp_q.push_back('{is_err: 1'b0, chk: 1'b1, dat: 32'h0000_000A});
        rsp_q.push_back('{is_err: 1'b0, chk: 1'b1, dat: 32'h0000_000A});
        wb_bus.adr = 32'h0000_0004;
        wb_bus.we  = 1'b0;
        wb_bus.sel = 4'hF;
        wb_bus.cyc = 1'b1;
        wb_bus.stb = 1'b1;
        @(negedge clk); check("held_req_cycle", 32'(wb_bus.ack), 32'd0);
        @(negedge clk); check("held_ack1", 32'(wb_bus.ack), 32'd1);
        @(negedge clk); check("held_gap", 32'({wb_bus.ack, wb_bus.err}), 32'd0);
        @(negedge clk); check("held_ack2", 32'(wb_bus.ack), 32'd1);
        @(posedge clk); #1;
        wb_bus.cyc = 1'b0;
        wb_bus.stb = 1'b0;

        wb_wr(R_RSV, 32'hFFFF_FFFF, 4'hF);
        wb_rd(R_RSV, 32'h0);

        // single TX word held until the consumer takes it
        tx_write(32'hDEAD_BEEF, 4'hF, 1'b1);
        @(negedge clk);
        check("tx_valid_after_wr", 32'(tx_valid), 32'd1);
        check("tx_data_after_wr", tx_data, 32'hDEAD_BEEF);
        @(posedge clk); #1 tx_ready = 1'b1;
        @(posedge clk); #1 tx_ready = 1'b0;
        @(negedge clk);
        check("tx_valid_after_pop", 32'(tx_valid), 32'd0);

        // fill RX from the stream, then drain it over the bus
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b1;
            rx_data  = 32'(i);
        end
        @(posedge clk); #1 rx_valid = 1'b0;
        @(negedge clk);
        check("rx_ready_full", 32'(rx_ready), 32'd0);
        wb_rd(R_STATUS, 32'h0008_0006);
        for (int i = 1; i <= 8; i++) wb_rd(R_DATA, 32'(i));
        wb_rd(R_STATUS, 32'h0000_000A);
        wb_xfer(1'b0, R_DATA, 32'h0, 4'hF, EXP_OVF_ERR, 1'b1, 32'h0);
        wb_rd(R_STATUS, 32'h0000_000A);

        // TX full: overflow write is rejected or dropped
        for (int i = 0; i < 8; i++) tx_write(32'h100 + 32'(i), 4'hF, 1'b1);
        wb_rd(R_STATUS, 32'h0000_0809);
        check("tx_head_full", tx_data, 32'h100);
        wb_xfer(1'b1, R_DATA, 32'h55, 4'hF, EXP_OVF_ERR, 1'b0, 32'h0);
        wb_rd(R_STATUS, 32'h0000_0809);

        // consumer drains while writes keep arriving; order must survive the wrap
        tx_ready = 1'b1;
        for (int k = 0; k < 7; k++) tx_write(32'h200 + 32'(k), 4'hF, 1'b1);
        repeat (12) @(posedge clk);
        #1 tx_ready = 1'b0;
        @(negedge clk);
        check("tx_drained_valid", 32'(tx_valid), 32'd0);
        check("tx_exp_left", 32'(tx_exp.size()), 32'd0);

        // interrupt enable, RX word arrival, RX flush
        wb_wr(R_CTRL, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        check("irq_en_rx_empty", 32'(irq), 32'd0);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = 32'h77;
        @(posedge clk); #1 rx_valid = 1'b0;
        @(negedge clk); check("irq_not_yet", 32'(irq), 32'd0);
        @(negedge clk); check("irq_set", 32'(irq), 32'd1);
        wb_rd(R_CTRL, 32'h1);
        wb_wr(R_CTRL, 32'h5, 4'hF);
        @(posedge clk);
        @(negedge clk);
        check("irq_after_flush", 32'(irq), 32'd0);
        check("rx_ready_after_flush", 32'(rx_ready), 32'd1);
        wb_rd(R_STATUS, 32'h0000_000A);
        wb_rd(R_CTRL, 32'h1);

        // CTRL writes only take effect with sel[0]
        wb_wr(R_CTRL, 32'h0, 4'b1110);
        wb_rd(R_CTRL, 32'h1);
        wb_wr(R_CTRL, 32'h0, 4'b0001);
        wb_rd(R_CTRL, 32'h0);

        // TX flush discards queued words
        tx_write(32'hA1, 4'hF, 1'b0);
        tx_write(32'hA2, 4'hF, 1'b0);
        wb_rd(R_STATUS, 32'h0000_0208);
        wb_wr(R_CTRL, 32'h2, 4'hF);
        wb_rd(R_STATUS, 32'h0000_000A);
        check("tx_valid_after_flush", 32'(tx_valid), 32'd0);

        // DATA ignores sel: full word pushed even with sel=0
        tx_write(32'h1234_5678, 4'h0, 1'b1);
        @(negedge clk);
        check("tx_data_sel0", tx_data, 32'h1234_5678);
        @(posedge clk); #1 tx_ready = 1'b1;
        @(posedge clk); #1 tx_ready = 1'b0;

        // reset during the response cycle aborts the access
        @(posedge clk); #1;
        wb_bus.adr   = 32'h0;
        wb_bus.we    = 1'b1;
        wb_bus.dat_o = 32'h0000_0BAD;
        wb_bus.sel   = 4'hF;
        wb_bus.cyc   = 1'b1;
        wb_bus.stb   = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_ack", 32'(wb_bus.ack), 32'd0);
        wb_bus.cyc = 1'b0;
        wb_bus.stb = 1'b0;
        wb_bus.we  = 1'b0;
        @(negedge clk);
        check("abort_tx_valid", 32'(tx_valid), 32'd0);
        check("abort_rx_ready", 32'(rx_ready), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        wb_rd(R_STATUS, 32'h0000_000A);

        repeat (2) @(negedge clk);
        check("rsp_left", 32'(rsp_q.size()), 32'd0);
        check("tx_left", 32'(tx_exp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, got no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_mailbox.md
WB_MAILBOX -- requirements
Module: wb_mailbox

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, giving the entries per FIFO; it SHALL be a power of 2 and at least 2.
REQ-002 The module SHALL have port clk_i  input  1  system clock; all state changes on the rising edge.
REQ-003 The module SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-004 The module SHALL have port wb  wishbone.slave  -  bus port; uses adr, dat_o, sel, we, cyc, stb; drives dat_i, ack, err, rty.
REQ-005 The module SHALL have port tx_valid_o  output  1  TX stream word valid.
REQ-006 The module SHALL have port tx_data_o  output  32  TX stream word.
REQ-007 The module SHALL have port tx_ready_i  input  1  TX stream consumer ready.
REQ-008 The module SHALL have port rx_valid_i  input  1  RX stream word valid.
REQ-009 The module SHALL have port rx_data_i  input  32  RX stream word.
REQ-010 The module SHALL have port rx_ready_o  output  1  RX FIFO can accept a word.
REQ-011 The module SHALL have port irq_o  output  1  level interrupt, registered.

Function
REQ-012 The module SHALL decode registers on adr[3:2] and SHALL ignore all other address bits.
- 0: DATA. A write pushes the TX FIFO. A read pops the RX FIFO.
- 1: STATUS, read-only.
- 2: CTRL.
- 3: reserved; reads 0, writes ignored.
REQ-013 The module SHALL give every access exactly one wait state.
- Request: stb&cyc high with ack/err low.
- Response: ack or err high for exactly one cycle, in the following cycle.
- ack/err SHALL be low in the cycle after a response, even if stb stays high.
REQ-014 rty SHALL be tied to 0.
REQ-015 cti and bte SHALL be ignored; burst beats SHALL each be handled as classic cycles.
REQ-016 All FIFO push, pop and CTRL updates SHALL commit on the clock edge that ends the response cycle; dat_i SHALL be valid while ack is high.
REQ-017 STATUS SHALL be laid out as follows, with all other bits 0:
- [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
- [15:8] tx_count, [23:16] rx_count.
REQ-018 CTRL SHALL be laid out as follows, each bit written only when sel[0]=1:
- [0] irq_en, read/write.
- [1] tx_flush, write-1 pulse, reads 0.
- [2] rx_flush, write-1 pulse, reads 0.
REQ-019 sel SHALL be ignored for DATA; every push is a full 32-bit word.
REQ-020 Both FIFOs SHALL use a circular buffer with log2(DEPTH)-bit pointers that wrap DEPTH-1 -> 0, and a count of width log2(DEPTH)+1 ranging 0..DEPTH.
REQ-021 The TX stream side SHALL behave as follows:
- tx_valid_o = !tx_empty; tx_data_o = head entry.
- A pop occurs on tx_valid_o & tx_ready_i.
REQ-022 The RX stream side SHALL behave as follows:
- rx_ready_o = !rx_full.
- A push occurs on rx_valid_i & rx_ready_o.
REQ-023 Simultaneous push and pop on one FIFO SHALL both occur and leave the count unchanged.
REQ-024 Full and empty for bus accesses SHALL be evaluated before any same-cycle stream-side pop or push.
REQ-025 A flush SHALL zero the pointers and count, and SHALL override any same-cycle stream push or pop on that FIFO; a stream handshake in that cycle still counts as completed by the peer.
REQ-026 irq_o SHALL be registered as irq_en & !rx_empty, one cycle after the state change.

Reset
REQ-027 While rst_i=0, the module SHALL drive:
- ack=0, err=0, irq_o=0, tx_valid_o=0, rx_ready_o=1.
- All FIFO pointers and counts 0, irq_en=0.
REQ-028 FIFO storage SHALL NOT be reset.
REQ-029 Reset asserted mid-access SHALL abort the access with no response; the master retries after reset.

Configuration
REQ-030 With WB_MAILBOX_ERR_EN defined, a DATA write with TX full and a DATA read with RX empty SHALL respond with err instead of ack, and FIFO state SHALL be unchanged.
REQ-031 Without WB_MAILBOX_ERR_EN, such a write SHALL be acked and the data dropped, and such a read SHALL be acked with dat_i=0; err SHALL be tied to 0.

Verification
REQ-032 Bench scenario: after reset, read STATUS -> ack on the 2nd cycle, dat_i=32'h0000_000A.
REQ-033 Bench scenario: write DATA 32'hDEAD_BEEF with tx_ready_i=0 -> tx_valid_o=1 and tx_data_o=32'hDEAD_BEEF; raise tx_ready_i for 1 cycle -> tx_valid_o=0.
REQ-034 Bench scenario: drive 8 RX stream words 1..8 -> rx_ready_o=0 and STATUS[23:16]=8; 8 DATA reads -> values 1..8 in order, then rx_empty=1.
REQ-035 Bench scenario: with DEPTH=8, TX full, and WB_MAILBOX_ERR_EN defined, write DATA 32'h55 -> err for 1 cycle, tx_count stays 8. Without the macro -> ack, tx_count stays 8.
REQ-036 Bench scenario: write CTRL 32'h1 with RX empty -> irq_o=0; push one RX word -> irq_o=1 one cycle later; write CTRL 32'h5 -> rx_empty=1 and irq_o=0 the next cycle.
REQ-037 Bench scenario: TX full with tx_ready_i=1 held for 20 cycles while DATA writes repeat -> ack/err and pointer wrap are correct, and the output order matches the write order.
